// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix row scanner: column count, default
// row count, scan state encoding and the row-drive idle level helper.
package matrix_pkg;

    localparam int COLS         = 5;
    localparam int ROWS_DEFAULT = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHOW  = 2'd2,
        ST_BLANK = 2'd3
    } scan_state_e;

    // Level that keeps a row dark for the given drive polarity.
    function automatic logic row_inactive_level(input logic active_low);
        if (active_low) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/matrix_row_scanner_tick.sv
// Phase tick counter shared by the SHOW and BLANK phases. Counts up from zero
// toward a run-time terminal value and holds there; never wraps.
module scan_tick_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             at_terminal
);

    logic [WIDTH-1:0] count_r;

    // Count register: clear wins, otherwise step toward the terminal value.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            count_r <= {WIDTH{1'b0}};
        end else if (enable && !at_terminal) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign at_terminal = (count_r == terminal);

endmodule

// File: rtl/matrix_row_scanner.sv
// Row multiplexer for a 5x7 LED matrix. Latches the column pattern once per
// frame, lights one row at a time and inserts dark gaps between rows.
module matrix_row_scanner
    import matrix_pkg::*;
#(
    parameter int ROWS           = ROWS_DEFAULT,
    parameter int TICKS_PER_ROW  = 50000,
    parameter int BLANK_TICKS    = 500,
    parameter int ROW_ACTIVE_LOW = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [COLS-1:0] col_in,
    output logic            col_enable,
    output logic [COLS-1:0] col_out,
    output logic [ROWS-1:0] row_out,
    output logic            frame_done
);

    localparam int TICK_MAX = (TICKS_PER_ROW > BLANK_TICKS) ? TICKS_PER_ROW : BLANK_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);
    localparam int ROW_W    = $clog2(ROWS);

    localparam logic [TICK_W-1:0] SHOW_TERM  = TICK_W'(TICKS_PER_ROW - 1);
    localparam logic [TICK_W-1:0] BLANK_TERM = TICK_W'((BLANK_TICKS > 0) ? (BLANK_TICKS - 1) : 0);
    localparam logic              HAS_BLANK  = (BLANK_TICKS > 0);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic              ROW_IDLE   = row_inactive_level(ROW_ACTIVE_LOW != 0);
    localparam logic [ROWS-1:0]   ROW_ONE    = {{(ROWS-1){1'b0}}, 1'b1};
    localparam logic [ROWS-1:0]   ROWS_DARK  = {ROWS{ROW_IDLE}};

    scan_state_e       state_r, state_s;
    logic [ROW_W-1:0]  row_idx_r, row_idx_s;
    logic [COLS-1:0]   col_latch_r, col_latch_s;
    logic              tick_clear_s, tick_en_s, tick_at_term_s;
    logic [TICK_W-1:0] tick_term_s;
    logic              row_end_s;
    logic [ROWS-1:0]   row_out_s;
    logic [COLS-1:0]   col_out_s;
    logic              col_enable_s, frame_done_s;

    scan_tick_counter #(.WIDTH(TICK_W)) u_tick (
        .clk         (clk),
        .reset       (reset),
        .clear       (tick_clear_s),
        .enable      (tick_en_s),
        .terminal    (tick_term_s),
        .at_terminal (tick_at_term_s)
    );

    // Next-state, tick control, row advance and end-of-frame decision.
    always_comb begin
        state_s      = state_r;
        row_idx_s    = row_idx_r;
        col_latch_s  = col_latch_r;
        tick_clear_s = 1'b0;
        tick_en_s    = 1'b0;
        row_end_s    = 1'b0;
        frame_done_s = 1'b0;
        tick_term_s  = (state_r == ST_BLANK) ? BLANK_TERM : SHOW_TERM;
        case (state_r)
            ST_IDLE: begin
                tick_clear_s = 1'b1;
                state_s      = run ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: begin
                col_latch_s  = col_in;
                row_idx_s    = {ROW_W{1'b0}};
                tick_clear_s = 1'b1;
                state_s      = ST_SHOW;
            end
            ST_SHOW: begin
                if (tick_at_term_s) begin
                    tick_clear_s = 1'b1;
                    row_end_s    = !HAS_BLANK;
                    state_s      = ST_BLANK;
                end else begin
                    tick_en_s = 1'b1;
                end
            end
            ST_BLANK: begin
                if (tick_at_term_s) begin
                    tick_clear_s = 1'b1;
                    row_end_s    = 1'b1;
                end else begin
                    tick_en_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // A finished row either moves to the next row or closes the frame.
        if (row_end_s && (row_idx_r == ROW_LAST)) begin
            frame_done_s = 1'b1;
            state_s      = run ? ST_LOAD : ST_IDLE;
        end else if (row_end_s) begin
            row_idx_s = row_idx_r + ROW_W'(1);
            state_s   = ST_SHOW;
        end else begin
            frame_done_s = 1'b0;
        end
    end

    // Output values for the upcoming state so outputs align with the state register.
    always_comb begin
        row_out_s    = ROWS_DARK;
        col_out_s    = {COLS{1'b0}};
        col_enable_s = (state_s != ST_IDLE);
        if (state_s == ST_SHOW) begin
            row_out_s = (ROW_ONE << row_idx_s) ^ ROWS_DARK;
            col_out_s = col_latch_s;
        end else begin
            row_out_s = ROWS_DARK;
            col_out_s = {COLS{1'b0}};
        end
    end

    // State, scan position, column latch and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            row_idx_r   <= {ROW_W{1'b0}};
            col_latch_r <= {COLS{1'b0}};
            col_enable  <= 1'b0;
            col_out     <= {COLS{1'b0}};
            row_out     <= ROWS_DARK;
            frame_done  <= 1'b0;
        end else begin
            state_r     <= state_s;
            row_idx_r   <= row_idx_s;
            col_latch_r <= col_latch_s;
            col_enable  <= col_enable_s;
            col_out     <= col_out_s;
            row_out     <= row_out_s;
            frame_done  <= frame_done_s;
        end
    end

endmodule
